mc_processor: RTL

MC_PROCESSOR -- requirements
Module: mc_processor

---
 rtl/mc_processor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mc_processor.sv
// Multi-cycle core: FETCH -> DECODE -> EXEC -> WB over a small register file.
// Jumps and branches retire from EXEC; HALT is left only through reset.
module mc_processor #(
   parameter int  DATA_W = 8,
   parameter int  NREGS  = 8,
   localparam int RA_W   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [31:0]       imem_addr,
   output logic              imem_req,
   input  logic              imem_ready,
   input  logic [31:0]       imem_data,
   output logic              wb_en,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              halted,
   output logic              illegal,
   output logic [2:0]        dbg_state
);

   // imem handshake: imem_req and imem_addr hold steady until a cycle with
   // imem_ready=1, which transfers imem_data; imem_ready without imem_req is ignored.

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h08;
   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h09;
   localparam logic [7:0] OP_AND   = 8'h02;
   localparam logic [7:0] OP_OR    = 8'h03;
   localparam logic [7:0] OP_J     = 8'h10;
   localparam logic [7:0] OP_BEQ   = 8'h11;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   state_t              state, state_nxt;
   logic [31:0]         pc;
   logic [7:0]          ir_op, ir_dest, ir_lo;
   logic [RA_W-1:0]     ir_src2;
   logic [DATA_W-1:0]   op_a, op_b, result, alu_res;
   logic [DATA_W-1:0]   regs [NREGS];
   logic [31:0]         br_off, br_tgt, br_pc;
   logic                is_alu, is_br, fetch_go;
   logic                unused_imem;

   // Only the low RA_W bits of the src2 field select a register.
   assign unused_imem = ^imem_data[15:8];

   assign fetch_go = (state == S_FETCH) && imem_req && imem_ready;
   assign is_alu   = (ir_op == OP_LOADI) || (ir_op == OP_MOV) || (ir_op == OP_ADD) ||
                     (ir_op == OP_SUB) || (ir_op == OP_AND) || (ir_op == OP_OR);
   assign is_br    = (ir_op == OP_J) || (ir_op == OP_BEQ);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         imem_req <= 1'b0;
      end else begin
         state    <= state_nxt;
         imem_req <= (state_nxt == S_FETCH);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (fetch_go) state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (is_alu)      state_nxt = S_WB;
            else if (is_br)  state_nxt = S_FETCH;
            else             state_nxt = S_HALT;
         end
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      imem_addr = pc;
      wb_en     = (state == S_WB);
      wb_addr   = wb_en ? ir_dest[RA_W-1:0] : '0;
      wb_data   = wb_en ? result : '0;
      halted    = (state == S_HALT);
      dbg_state = state;
   end

   always_comb begin
      alu_res = '0;
      case (ir_op)
         OP_LOADI: alu_res = DATA_W'(ir_lo);
         OP_MOV:   alu_res = op_a;
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a + (~op_b + DATA_W'(1));
         OP_AND:   alu_res = op_a & op_b;
         OP_OR:    alu_res = op_a | op_b;
         default:  alu_res = '0;
      endcase
   end

   // Branch offset is a signed word count relative to the following instruction.
   always_comb begin
      br_off = {{22{ir_dest[7]}}, ir_dest, 2'b00};
      br_tgt = pc + 32'd4 + br_off;
      br_pc  = ((ir_op == OP_J) || (op_a == op_b)) ? br_tgt : pc + 32'd4;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= '0;
         ir_op   <= '0;
         ir_dest <= '0;
         ir_lo   <= '0;
         ir_src2 <= '0;
         op_a    <= '0;
         op_b    <= '0;
         result  <= '0;
         illegal <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (fetch_go) begin
                  ir_op   <= imem_data[31:24];
                  ir_dest <= imem_data[23:16];
                  ir_src2 <= imem_data[8 +: RA_W];
                  ir_lo   <= imem_data[7:0];
               end
            end
            S_DECODE: begin
               op_a <= regs[ir_lo[RA_W-1:0]];
               op_b <= regs[ir_src2];
            end
            S_EXEC: begin
               result <= alu_res;
               if (is_br) pc <= br_pc;
               if (!is_alu && !is_br) illegal <= (ir_op != OP_HALT);
            end
            S_WB: begin
               regs[ir_dest[RA_W-1:0]] <= result;
               pc <= pc + 32'd4;
            end
            default: ;
         endcase
      end
   end

endmodule
